f8_mem_arbiter: RTL and testbench

Two-master arbiter sharing the single synchronous memory port of the f8 system. Master 0 is the f8 core's bus and master 1 is a DMA/debug requester. Performs single-cycle round-robin arbitration, drives the memory port, and routes read data back to the owning master after a fixed memory latency. Sits between the core and the system RAM inside the system top.

---
 rtl/f8_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_f8_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f8_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : f8_mem_arbiter
//  Purpose  : Two-master round-robin arbiter in front of the single
//             synchronous memory port of the f8 system. Master 0 is the
//             core bus, master 1 is the DMA/debug requester. Grants are
//             combinational, and read data is routed back to its owner
//             after a fixed memory latency.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             mX_req/addr/wdata/we   - master X request (held until gnt)
//             mX_gnt                 - master X access accepted this cycle
//             mX_rvalid/rdata        - master X read return
//             mem_en/we/addr/wdata   - memory port strobe and command
//             mem_rdata              - memory read data (READ_LATENCY later)
//  Revision : 1.0 - initial release
// ============================================================================
module f8_mem_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1   // legal range 1..4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic                  m0_we,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic                  m1_we,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // last_winner: 0 = master 0 won the last contest, 1 = master 1 did.
   logic                    last_winner_q, last_winner_d;
   logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
   logic [READ_LATENCY-1:0] rd_own_q, rd_own_d;
   logic                    both_req;
   logic                    push_vld;

   assign both_req = m0_req & m1_req;

   // Grant decision and pointer update.
   always_comb begin
      m0_gnt        = 1'b0;
      m1_gnt        = 1'b0;
      last_winner_d = last_winner_q;
      if (!reset) begin
         if (both_req) begin
            // The master that lost the previous contest wins this one.
            m0_gnt        = last_winner_q;
            m1_gnt        = ~last_winner_q;
            last_winner_d = ~last_winner_q;
         end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
         end
      end
   end

   // Memory port mux; all zeros when idle.
   always_comb begin
      mem_en    = m0_gnt | m1_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (m0_gnt) begin
         mem_we    = m0_we;
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
      end else if (m1_gnt) begin
         mem_we    = m1_we;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
      end
   end

   // Read-return pipeline: stage 0 takes the current grant, the last stage
   // lines up with mem_rdata for that access.
   assign push_vld = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

   always_comb begin
      rd_vld_d    = '0;
      rd_own_d    = '0;
      rd_vld_d[0] = push_vld;
      rd_own_d[0] = m1_gnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
         rd_vld_d[i] = rd_vld_q[i-1];
         rd_own_d[i] = rd_own_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_winner_q <= 1'b1;
         rd_vld_q      <= '0;
         rd_own_q      <= '0;
      end else begin
         last_winner_q <= last_winner_d;
         rd_vld_q      <= rd_vld_d;
         rd_own_q      <= rd_own_d;
      end
   end

   assign m0_rvalid = rd_vld_q[READ_LATENCY-1] & ~rd_own_q[READ_LATENCY-1];
   assign m1_rvalid = rd_vld_q[READ_LATENCY-1] &  rd_own_q[READ_LATENCY-1];
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_f8_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_f8_mem_arbiter
//  Purpose  : Self-checking bench for f8_mem_arbiter. Three instances with
//             READ_LATENCY 1, 2 and 3 share the same request stimulus; each
//             has its own memory model. A reference model (winner pointer,
//             RAM image and a per-latency return schedule) predicts every
//             output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_f8_mem_arbiter;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic [15:0] m0_addr = '0, m1_addr = '0;
   logic [7:0]  m0_wdata = '0, m1_wdata = '0;
   logic        m0_we = 1'b0, m1_we = 1'b0;

   logic [NI-1:0] gnt0_a, gnt1_a, rv0_a, rv1_a, men_a, mwe_a;
   logic [7:0]    rd0_a   [NI];
   logic [7:0]    rd1_a   [NI];
   logic [15:0]   maddr_a [NI];
   logic [7:0]    mwd_a   [NI];
   logic [7:0]    mrd_a   [NI];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      logic [7:0] ram   [1024];
      logic [7:0] rpipe [4];

      initial begin
         for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 3);
      end

      // Synchronous memory: read data emerges LAT cycles after the strobe.
      always @(posedge clk) begin
         for (int i = 3; i > 0; i--) rpipe[i] <= rpipe[i-1];
         if (men_a[k]) begin
            if (mwe_a[k]) ram[maddr_a[k][9:0]] <= mwd_a[k];
            else          rpipe[0] <= ram[maddr_a[k][9:0]];
         end
      end
      assign mrd_a[k] = rpipe[k];

      f8_mem_arbiter #(
         .ADDR_WIDTH  (16),
         .DATA_WIDTH  (8),
         .READ_LATENCY(k + 1)
      ) u_dut (
         .clk      (clk),
         .reset    (reset),
         .m0_req   (m0_req),
         .m0_addr  (m0_addr),
         .m0_wdata (m0_wdata),
         .m0_we    (m0_we),
         .m0_gnt   (gnt0_a[k]),
         .m0_rvalid(rv0_a[k]),
         .m0_rdata (rd0_a[k]),
         .m1_req   (m1_req),
         .m1_addr  (m1_addr),
         .m1_wdata (m1_wdata),
         .m1_we    (m1_we),
         .m1_gnt   (gnt1_a[k]),
         .m1_rvalid(rv1_a[k]),
         .m1_rdata (rd1_a[k]),
         .mem_en   (men_a[k]),
         .mem_we   (mwe_a[k]),
         .mem_addr (maddr_a[k]),
         .mem_wdata(mwd_a[k]),
         .mem_rdata(mrd_a[k])
      );
   end

   // ---------------- reference model state ----------------
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   bit         mdl_m1_won_last = 1'b1;   // who won the last contest
   logic [7:0] mram [1024];
   bit         sv [NI][8];                // return scheduled in this slot
   bit         so [NI][8];                // owner of that return
   logic [7:0] sd [NI][8];                // data it must carry
   bit         g0, g1;                    // grants predicted for this cycle

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs are already driven (just after negedge).
   task automatic cycle(input bit rst_in);
      bit         e_en, e_we;
      logic [15:0] e_addr;
      logic [7:0]  e_wd;
      int          slot;
      string       p;
      reset = rst_in;
      #1;
      if (rst_in)                { g0, g1 } = 2'b00;
      else if (m0_req && m1_req) { g0, g1 } = mdl_m1_won_last ? 2'b10 : 2'b01;
      else                       { g0, g1 } = { m0_req, m1_req };
      e_en   = g0 | g1;
      e_we   = g0 ? m0_we    : (g1 ? m1_we    : 1'b0);
      e_addr = g0 ? m0_addr  : (g1 ? m1_addr  : 16'h0);
      e_wd   = g0 ? m0_wdata : (g1 ? m1_wdata : 8'h0);
      slot   = cyc % 8;
      for (int k = 0; k < NI; k++) begin
         p = $sformatf("L%0d_c%0d", k + 1, cyc);
         chk({p, "_gnt0"},   32'(gnt0_a[k]),  32'(g0));
         chk({p, "_gnt1"},   32'(gnt1_a[k]),  32'(g1));
         chk({p, "_mem_en"}, 32'(men_a[k]),   32'(e_en));
         chk({p, "_mem_we"}, 32'(mwe_a[k]),   32'(e_we));
         chk({p, "_addr"},   32'(maddr_a[k]), 32'(e_addr));
         chk({p, "_wdata"},  32'(mwd_a[k]),   32'(e_wd));
         chk({p, "_rvalid0"}, 32'(rv0_a[k]), 32'(sv[k][slot] && !so[k][slot]));
         chk({p, "_rvalid1"}, 32'(rv1_a[k]), 32'(sv[k][slot] &&  so[k][slot]));
         if (sv[k][slot]) begin
            if (so[k][slot]) chk({p, "_rdata1"}, 32'(rd1_a[k]), 32'(sd[k][slot]));
            else             chk({p, "_rdata0"}, 32'(rd0_a[k]), 32'(sd[k][slot]));
         end
         sv[k][slot] = 1'b0;
      end
      if (rst_in) begin
         mdl_m1_won_last = 1'b1;
         for (int k = 0; k < NI; k++)
            for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
      end else begin
         if (m0_req && m1_req) mdl_m1_won_last = g1;
         if (e_en && !e_we) begin
            for (int k = 0; k < NI; k++) begin
               sv[k][(cyc + k + 1) % 8] = 1'b1;
               so[k][(cyc + k + 1) % 8] = g1;
               sd[k][(cyc + k + 1) % 8] = mram[e_addr[9:0]];
            end
         end else if (e_en) begin
            mram[e_addr[9:0]] = e_wd;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic set_m0(input bit req, input bit we, input logic [15:0] a, input logic [7:0] d);
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
   endtask

   task automatic set_m1(input bit req, input bit we, input logic [15:0] a, input logic [7:0] d);
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
   endtask

   task automatic idle(input int n);
      set_m0(0, 0, 16'h0, 8'h0);
      set_m1(0, 0, 16'h0, 8'h0);
      for (int i = 0; i < n; i++) cycle(0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mram[i] = 8'(i * 7 + 3);
      @(negedge clk);

      // Reset state, requests held high to show reset blocks grants.
      set_m0(1, 0, 16'h0033, 8'h0);
      set_m1(1, 0, 16'h0044, 8'h0);
      cycle(1);
      idle(0);
      cycle(1);

      // Lone m0 read of 0x0010.
      set_m0(1, 0, 16'h0010, 8'h0);
      cycle(0);
      idle(5);

      // Both reading continuously from reset: grants alternate m0 first.
      cycle(1);
      for (int i = 0; i < 6; i++) begin
         set_m0(1, 0, 16'(16 + i), 8'h0);
         set_m1(1, 0, 16'(32 + i), 8'h0);
         cycle(0);
      end
      idle(5);

      // m1 writes 0xA5 to 0x0200, then m0 reads it back.
      set_m1(1, 1, 16'h0200, 8'hA5);
      cycle(0);
      set_m1(0, 0, 16'h0, 8'h0);
      set_m0(1, 0, 16'h0200, 8'h0);
      cycle(0);
      idle(5);

      // Consecutive reads m0 @1, m1 @2, m0 @3.
      set_m0(1, 0, 16'h0001, 8'h0); cycle(0);
      set_m0(0, 0, 16'h0, 8'h0);
      set_m1(1, 0, 16'h0002, 8'h0); cycle(0);
      set_m1(0, 0, 16'h0, 8'h0);
      set_m0(1, 0, 16'h0003, 8'h0); cycle(0);
      idle(5);

      // Contest goes to m1, uncontested m0 x4, then contest goes to m0.
      cycle(1);
      set_m0(1, 0, 16'h0050, 8'h0);
      set_m1(1, 0, 16'h0060, 8'h0);
      cycle(0);                               // m0 wins
      set_m0(1, 0, 16'h0051, 8'h0);
      cycle(0);                               // m1 wins
      set_m1(0, 0, 16'h0, 8'h0);
      for (int i = 0; i < 4; i++) begin
         set_m0(1, 0, 16'(16'h0070 + i), 8'h0);
         cycle(0);
      end
      set_m1(1, 0, 16'h0061, 8'h0);
      cycle(0);                               // m0 wins again
      idle(5);

      // m1 read in flight, then a one-cycle reset drops it.
      set_m1(1, 0, 16'h0123, 8'h0);
      cycle(0);
      set_m1(0, 0, 16'h0, 8'h0);
      cycle(1);
      set_m0(1, 0, 16'h0124, 8'h0);
      set_m1(1, 0, 16'h0125, 8'h0);
      cycle(0);                               // m0 wins first contest
      idle(5);

      // Randomised traffic honouring the hold-until-grant handshake.
      for (int i = 0; i < 400; i++) begin
         bit r;
         r = ($urandom_range(0, 59) == 0);
         cycle(r);
         if (g0 || !m0_req)
            set_m0($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                   16'($urandom_range(0, 1023)), 8'($urandom));
         if (g1 || !m1_req)
            set_m1($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                   16'($urandom_range(0, 1023)), 8'($urandom));
      end
      idle(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
